// File: rtl/cpu32_mem_pkg.sv
// Shared constants and byte-enable merge helper for the CPU32 memory blocks.
package cpu32_mem_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 1024;
  localparam int MAX_RD_LAT = 4;
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  // Enabled bytes come from new_w, the rest keep old_w; callers zero-extend narrower words.
  function automatic logic [MAX_DATA_W-1:0] be_merge(input logic [MAX_DATA_W-1:0] old_w,
                                                     input logic [MAX_DATA_W-1:0] new_w,
                                                     input logic [MAX_BE_W-1:0]   be);
    logic [MAX_DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BE_W; i++) m[8*i +: 8] = {8{be[i]}};
    return (old_w & ~m) | (new_w & m);
  endfunction
endpackage

// File: rtl/ram_rd_pipe.sv
// STAGES-deep delay line for read results {valid, exc, data}; async clear drops in-flight reads.
module ram_rd_pipe #(
  parameter int W      = 32,
  parameter int STAGES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic         in_exc,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic         out_exc,
  output logic [W-1:0] out_data
);
  logic [STAGES:1]         vld_pipe;
  logic [STAGES:1]         exc_pipe;
  logic [STAGES:1][W-1:0]  data_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      exc_pipe  <= '0;
      data_pipe <= '0;
    end else begin
      vld_pipe[1]  <= in_vld;
      exc_pipe[1]  <= in_exc;
      data_pipe[1] <= in_data;
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        exc_pipe[s]  <= exc_pipe[s-1];
        data_pipe[s] <= data_pipe[s-1];
      end
    end
  end

  assign out_vld  = vld_pipe[STAGES];
  assign out_exc  = exc_pipe[STAGES];
  assign out_data = data_pipe[STAGES];
endmodule

// File: rtl/param_dp_ram.sv
// 1R/1W synchronous RAM with byte enables, RD_LAT-cycle pipelined reads and range exceptions.
// Define RAM_FWD_EN for write-first behaviour on same-edge same-address read/write.
module param_dp_ram
  import cpu32_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read,
  input  logic [ADDR_W-1:0]   r_addr,
  output logic [DATA_W-1:0]   r_line,
  output logic                rrdy,
  output logic                r_exc,
  input  logic                write,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [DATA_W-1:0]   w_line,
  input  logic [DATA_W/8-1:0] w_be,
  output logic                wrdy,
  output logic                w_exc,
  output logic                exc
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_lat
    $error("param_dp_ram: RD_LAT out of range");
  end
  if (DATA_W % 8 != 0 || DATA_W > MAX_DATA_W || ADDR_W < IDX_W) begin : g_bad_geom
    $error("param_dp_ram: unsupported DATA_W/ADDR_W/DEPTH");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              r_hit, w_hit;
  logic [IDX_W-1:0]  r_idx, w_idx;
  logic [DATA_W-1:0] wr_word, rd_word;
  logic              p_vld, p_exc;

  // Full-width unsigned compare so huge addresses never alias into the array.
  assign r_hit = {1'b0, r_addr} < DEPTH_X;
  assign w_hit = {1'b0, w_addr} < DEPTH_X;
  assign r_idx = r_addr[IDX_W-1:0];
  assign w_idx = w_addr[IDX_W-1:0];

  assign wr_word = DATA_W'(be_merge(MAX_DATA_W'(mem[w_idx]), MAX_DATA_W'(w_line),
                                    MAX_BE_W'(w_be)));

  always_comb begin
    rd_word = mem[r_idx];
`ifdef RAM_FWD_EN
    if (write && w_hit && r_addr == w_addr) rd_word = wr_word;
`endif
  end

  // Array holds no reset; a write seen while rst is high is dropped.
  always_ff @(posedge clk) begin
    if (!rst && write && w_hit) mem[w_idx] <= wr_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrdy  <= 1'b0;
      w_exc <= 1'b0;
    end else begin
      wrdy  <= write & w_hit;
      w_exc <= write & ~w_hit;
    end
  end

  // Data is zeroed at entry for idle or out-of-range slots so r_line needs no output mux.
  ram_rd_pipe #(.W(DATA_W), .STAGES(RD_LAT)) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (read),
    .in_exc   (~r_hit),
    .in_data  ((read && r_hit) ? rd_word : '0),
    .out_vld  (p_vld),
    .out_exc  (p_exc),
    .out_data (r_line)
  );

  assign rrdy  = p_vld & ~p_exc;
  assign r_exc = p_vld & p_exc;
  assign exc   = r_exc | w_exc;
endmodule

// File: tb/tb_param_dp_ram.sv
// Random + directed bench: two instances (RD_LAT=1 and 4) share inputs, checked against a word-array model.
module tb_param_dp_ram;
  localparam int LAT_A = 1;
  localparam int LAT_B = 4;

  typedef struct packed {
    logic        rrdy;
    logic        rexc;
    logic [31:0] d;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        read = 1'b0, write = 1'b0;
  logic [31:0] r_addr = '0, w_addr = '0, w_line = '0;
  logic [3:0]  w_be = '0;

  logic [31:0] a_line, b_line;
  logic        a_rrdy, a_rexc, a_wrdy, a_wexc, a_exc;
  logic        b_rrdy, b_rexc, b_wrdy, b_wexc, b_exc;

  logic [31:0] mem_m [0:1023];
  res_t        qa[$], qb[$];
  bit          exp_wrdy, exp_wexc;
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  param_dp_ram #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .RD_LAT(LAT_A)) u_a (
    .clk(clk), .rst(rst), .read(read), .r_addr(r_addr), .r_line(a_line), .rrdy(a_rrdy),
    .r_exc(a_rexc), .write(write), .w_addr(w_addr), .w_line(w_line), .w_be(w_be),
    .wrdy(a_wrdy), .w_exc(a_wexc), .exc(a_exc));

  param_dp_ram #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .RD_LAT(LAT_B)) u_b (
    .clk(clk), .rst(rst), .read(read), .r_addr(r_addr), .r_line(b_line), .rrdy(b_rrdy),
    .r_exc(b_rexc), .write(write), .w_addr(w_addr), .w_line(w_line), .w_be(w_be),
    .wrdy(b_wrdy), .w_exc(b_wexc), .exc(b_exc));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_all(input res_t ea, input res_t eb);
    chk("a_rrdy",  32'(a_rrdy), 32'(ea.rrdy));
    chk("a_r_exc", 32'(a_rexc), 32'(ea.rexc));
    chk("a_r_line", a_line, ea.d);
    chk("a_wrdy",  32'(a_wrdy), 32'(exp_wrdy));
    chk("a_w_exc", 32'(a_wexc), 32'(exp_wexc));
    chk("a_exc",   32'(a_exc),  32'(ea.rexc | exp_wexc));
    chk("b_rrdy",  32'(b_rrdy), 32'(eb.rrdy));
    chk("b_r_exc", 32'(b_rexc), 32'(eb.rexc));
    chk("b_r_line", b_line, eb.d);
    chk("b_wrdy",  32'(b_wrdy), 32'(exp_wrdy));
    chk("b_w_exc", 32'(b_wexc), 32'(exp_wexc));
    chk("b_exc",   32'(b_exc),  32'(eb.rexc | exp_wexc));
  endtask

  // One clock: drive at negedge, update the model at the edge, compare 1 time unit later.
  task automatic step(input bit rd, input logic [31:0] ra, input bit wr,
                      input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] be);
    res_t        r, ea, eb;
    bit          rin, win;
    logic [31:0] old_w, merged;
    @(negedge clk);
    read = rd; r_addr = ra; write = wr; w_addr = wa; w_line = wd; w_be = be;
    @(posedge clk);
    rin = (ra < 32'd1024);
    win = (wa < 32'd1024);
    old_w  = win ? mem_m[wa[9:0]] : 32'h0;
    merged = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) merged[8*i +: 8] = wd[8*i +: 8];
    r = '0;
    if (rd) begin
      if (rin) begin
        r.rrdy = 1'b1;
        r.d    = mem_m[ra[9:0]];
`ifdef RAM_FWD_EN
        if (wr && win && wa == ra) r.d = merged;
`endif
      end else begin
        r.rexc = 1'b1;
      end
    end
    if (wr && win) mem_m[wa[9:0]] = merged;
    exp_wrdy = wr && win;
    exp_wexc = wr && !win;
    qa.push_back(r);
    if (qa.size() > LAT_A) void'(qa.pop_front());
    qb.push_back(r);
    if (qb.size() > LAT_B) void'(qb.pop_front());
    #1;
    ea = (qa.size() == LAT_A) ? qa[0] : '0;
    eb = (qb.size() == LAT_B) ? qb[0] : '0;
    check_all(ea, eb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 4'h0);
  endtask

  // Reset across one edge, optionally with a write presented that must not land.
  task automatic do_reset(input bit wr, input logic [31:0] wa, input logic [31:0] wd);
    @(negedge clk);
    rst = 1'b1; read = 1'b1; r_addr = 0; write = wr; w_addr = wa; w_line = wd; w_be = 4'hF;
    qa.delete(); qb.delete();
    exp_wrdy = 0; exp_wexc = 0;
    #1 check_all('0, '0);
    @(posedge clk);
    #1 check_all('0, '0);
    rst = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  initial begin
    do_reset(0, 0, 0);
    for (int i = 0; i < 1024; i++) step(0, 0, 1, 32'(i), $urandom, 4'hF);
    idle(LAT_B);

    // Basic write then read.
    step(0, 0, 1, 5, 32'hDEADBEEF, 4'hF);
    step(1, 5, 0, 0, 0, 4'h0);
    chk("dir_deadbeef", a_line, 32'hDEADBEEF);

    // Back-to-back reads of a preloaded block.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'(i), 32'h10 + 32'(i), 4'hF);
    for (int i = 0; i < 4; i++) step(1, 32'(i), 0, 0, 0, 4'h0);
    idle(LAT_B);

    // Byte-enable merge.
    step(0, 0, 1, 7, 32'hFFFFFFFF, 4'hF);
    step(0, 0, 1, 7, 32'h00000000, 4'b0101);
    step(1, 7, 0, 0, 0, 4'h0);
    chk("dir_be_merge", a_line, 32'hFF00FF00);

    // Both ports out of range, then confirm address 0 intact.
    step(1, 1024, 1, 32'hFFFFFFFF, 32'h5555AAAA, 4'hF);
    chk("dir_oor_exc", 32'(a_exc), 32'd1);
    step(1, 0, 0, 0, 0, 4'h0);
    chk("dir_addr0", a_line, 32'h10);
    idle(LAT_B);

    // Same-edge read/write collision.
    step(0, 0, 1, 9, 32'h1, 4'hF);
    step(1, 9, 1, 9, 32'h2, 4'hF);
`ifdef RAM_FWD_EN
    chk("dir_collide", a_line, 32'h2);
`else
    chk("dir_collide", a_line, 32'h1);
`endif
    idle(LAT_B);

    // Reset with reads in flight and a write that must be dropped.
    step(1, 1, 0, 0, 0, 4'h0);
    step(1, 2, 0, 0, 0, 4'h0);
    do_reset(1, 5, 32'h12345678);
    idle(LAT_B + 2);
    step(1, 5, 0, 0, 0, 4'h0);
    chk("dir_reset_keep", a_line, 32'hDEADBEEF);
    idle(LAT_B);

    // Random traffic, including out-of-range addresses and rare resets.
    for (int n = 0; n < 800; n++) begin
      logic [31:0] ra, wa;
      ra = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : 32'd1024 + 32'($urandom_range(0, 15)))
                                       : 32'($urandom_range(0, 1023));
      wa = ($urandom_range(0, 7) == 0) ? 32'd1024 + 32'($urandom_range(0, 3))
                                       : (($urandom_range(0, 1) == 0) ? ra : 32'($urandom_range(0, 63)));
      if ($urandom_range(0, 99) == 0) do_reset(1'($urandom_range(0, 1)), wa, $urandom);
      else step(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom));
    end
    idle(LAT_B + 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/param_dp_ram.md
Name: param_dp_ram

Overview:
- Parametrised two-port synchronous RAM (one read port, one write port) for CPU32 instruction/data memory.
- Generalises width, depth and read latency.
- Adds per-byte write enables, a pipelined read path accepting one request per cycle, and separate read/write exception pulses.
- Sits between the CPU32 memory stage and the bus; the core drives requests directly.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 32, address port width; word-addressed.
- DEPTH, 1024, number of words; valid addresses are 0..DEPTH-1.
- RD_LAT, 1, read latency in cycles, range 1..4.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- read  in  1  read request; sampled every rising edge
- r_addr  in  ADDR_W  read word address
- r_line  out  DATA_W  read data; valid only while rrdy=1
- rrdy  out  1  one-cycle pulse: r_line valid
- r_exc  out  1  one-cycle pulse: read address out of range
- write  in  1  write request
- w_addr  in  ADDR_W  write word address
- w_line  in  DATA_W  write data
- w_be  in  DATA_W/8  byte enables; bit i covers w_line[8i+7:8i]
- wrdy  out  1  one-cycle pulse: write committed
- w_exc  out  1  one-cycle pulse: write address out of range
- exc  out  1  r_exc | w_exc (combinational OR)

Behaviour:
- Reset, asynchronous: r_line=0, rrdy=0, r_exc=0, wrdy=0, w_exc=0. All read-pipeline valid bits are cleared. Memory contents are not reset.
- Reset mid-operation: all in-flight reads are dropped, with no rrdy or r_exc for them. A write sampled at the same edge rst is asserted is not committed.
- Read acceptance: read=1 at an edge accepts a request. There is no back-pressure; back-to-back reads give one result per cycle.
- Read latency: for a request accepted at edge N, rrdy or r_exc pulses for exactly one cycle after edge N+RD_LAT-1, i.e. visible in cycle N+RD_LAT. Results return in request order.
- In-range read (r_addr < DEPTH, full ADDR_W unsigned compare): rrdy=1, r_line=mem[r_addr], r_exc=0.
- Out-of-range read: rrdy=0, r_exc=1, r_line=0.
- When no result is due, rrdy=0, r_exc=0 and r_line=0. The output is never high-Z.
- Write: write=1 at an edge with w_addr < DEPTH updates the enabled bytes of mem[w_addr] at that edge. wrdy=1 for the following cycle; bytes with w_be=0 keep their old value.
- w_be all zero: the write still pulses wrdy, with no change to memory.
- Out-of-range write: memory is unchanged, wrdy=0, w_exc=1 for one cycle.
- Simultaneous read and write, same address, same edge: the read returns the pre-write value (read-first), unless RAM_FWD_EN is defined.
- Writes in the cycles between read acceptance and result are not visible to that read. The array is sampled at the accept edge, and later pipeline stages only delay.
- A read and a write both out of range in the same cycle: r_exc and w_exc assert independently in their own result cycles; exc is the OR of the two.
- No internal state machine beyond the RD_LAT-deep shift pipeline of {valid, exc, data}.

Optional Feature:
- Macro: RAM_FWD_EN.
- Defined: a same-edge, same-address, in-range read and write returns the merged value. Enabled bytes come from w_line, the rest from the old word. This is write-first behaviour.
- Undefined: read-first, as described above.
- No other behaviour differs.

Decomposition:
- Package cpu32_mem_pkg holds:
  - the default DATA_W and DEPTH constants;
  - a function computing the byte-enable merge;
  - a constant MAX_RD_LAT=4, used in a parameter range check.
- Sub-module ram_rd_pipe: the parametrised RD_LAT-stage shift register for {valid, exc, data}, with asynchronous clear.
- The top level holds the array, the address checks, write merging and forwarding.

Test Plan:
- Reset then write 0xDEADBEEF to address 5 with w_be=4'hF, then read address 5 with RD_LAT=1: wrdy pulses in the cycle after the write edge; rrdy and r_line=0xDEADBEEF appear one cycle after the read edge.
- RD_LAT=3, reads of addresses 0,1,2,3 on consecutive edges, preloaded with 0x10..0x13: rrdy is high for 4 consecutive cycles starting 3 cycles after the first edge, with data 0x10,0x11,0x12,0x13 in order.
- Write 0xFFFFFFFF to address 7, then write 0x00000000 with w_be=4'b0101: a read of address 7 returns 0xFF00FF00.
- Read address 1024 and write address 0xFFFFFFFF with DEPTH=1024: r_exc and w_exc each pulse for one cycle and exc is high; rrdy=0, wrdy=0, r_line=0; address 0 is unchanged.
- Address 9 holds 0x1; same edge: write 0x2 and read address 9. Without RAM_FWD_EN r_line=0x1; with it r_line=0x2.
- RD_LAT=4, two reads in flight, assert rst for 1 cycle: all outputs go to 0 immediately; no rrdy appears afterward; memory retains earlier written values.
